// File: rtl/park_pkg.sv
// Shared definitions for the parking-controller timer scheduler: FSM state
// encoding, default sizing constants and the one-hot-to-index helper.
package park_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N_REQ    = 3;
  localparam int DEF_CNT_W    = 8;
  localparam int DEF_TICK_DIV = 1000;

  // Widest request vector the index helper accepts.
  localparam int MAX_REQ = 32;

  // Index of the set bit in a one-hot vector; 0 when no bit is set.
  function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Tick prescaler: counts 0..TICK_DIV-1 on clk and strobes tick while the
// count sits at TICK_DIV-1. Synchronous clear restarts the count at 0.
// Optional feature macro: TIMER_PAUSE_EN adds a hold input that freezes the
// count and suppresses the strobe.
module tick_gen
  import park_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
`ifdef TIMER_PAUSE_EN
  input  logic hold,
`endif
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] count;

  // Free-running wrap counter, cleared on reset or on a new grant.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
`ifdef TIMER_PAUSE_EN
    end else if (hold) begin
      count <= count;
`endif
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

`ifdef TIMER_PAUSE_EN
  assign tick = (count == LAST) && !hold;
`else
  assign tick = (count == LAST);
`endif

endmodule

// File: rtl/park_timer_sched.sv
// Shared countdown-timer scheduler. A round-robin arbiter hands one
// tick-driven countdown to one of N_REQ requesters, loads its duration and
// pulses done to the owner on expiry. Dropping req while owning aborts.
// Handshake: req is a level held by requester i for as long as it wants or
// owns the timer; grant[i] answers it one cycle later, done[i] pulses once on
// expiry, and the grant is released the cycle after done or after req drops.
// Optional feature macro: TIMER_PAUSE_EN adds a pause input that freezes the
// countdown and prescaler while in RUN.
module park_timer_sched
  import park_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] dur,
`ifdef TIMER_PAUSE_EN
  input  logic                   pause,
`endif
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic [CNT_W-1:0]       remaining,
  output logic [N_REQ-1:0]       done,
  output logic                   tick
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // FSM state is kept as a named internal signal so checkers can bind to it.
  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] next_ptr;
  logic [CNT_W-1:0] win_dur;
  logic             owner_req;
  logic             load;

  // Round-robin scan: first set req bit starting at rr_ptr, wrapping around.
  always_comb begin
    logic found;
    int   idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = (int'(rr_ptr) + off) % N_REQ;
      if (!found && req[idx]) begin
        winner = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

  // Owner bookkeeping derived from the registered one-hot grant.
  always_comb begin
    owner     = IDX_W'(onehot_to_idx(MAX_REQ'(grant)));
    owner_req = req[owner];
    win_dur   = dur[int'(winner)*CNT_W +: CNT_W];
    next_ptr  = (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;
  end

  assign load = (state == IDLE) && (|req);
  assign busy = |grant;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (load),
`ifdef TIMER_PAUSE_EN
    .hold  (pause && (state == RUN)),
`endif
    .tick  (tick)
  );

  // Arbitration, countdown and expiry FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      remaining <= '0;
      done      <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          if (|req) begin
            grant     <= N_REQ'(1) << winner;
            remaining <= win_dur;
            if (win_dur == '0) begin
              state <= DONE;
              done  <= N_REQ'(1) << winner;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (!owner_req) begin
            // Abort takes priority over any tick in the same cycle.
            state     <= IDLE;
            grant     <= '0;
            remaining <= '0;
            rr_ptr    <= next_ptr;
          end else if (tick) begin
            if (remaining == CNT_W'(1)) begin
              remaining <= '0;
              state     <= DONE;
              done      <= grant;
            end else if (remaining != '0) begin
              remaining <= remaining - 1'b1;
            end
          end
        end
        DONE: begin
          done   <= '0;
          grant  <= '0;
          state  <= IDLE;
          rr_ptr <= next_ptr;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          done  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_park_timer_sched.sv
// Directed bench for park_timer_sched with TICK_DIV=4, N_REQ=3, CNT_W=8.
// Cycle numbers in comments count from the cycle in which req is applied.
module tb_park_timer_sched;

  localparam int N  = 3;
  localparam int CW = 8;
  localparam int TD = 4;

  logic          clk;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*CW-1:0] dur;
  logic [N-1:0]  grant;
  logic          busy;
  logic [CW-1:0] remaining;
  logic [N-1:0]  done;
  logic          tick;
`ifdef TIMER_PAUSE_EN
  logic          pause;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [N-1:0] exp_q[$];

  park_timer_sched #(
    .N_REQ    (N),
    .CNT_W    (CW),
    .TICK_DIV (TD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .dur       (dur),
`ifdef TIMER_PAUSE_EN
    .pause     (pause),
`endif
    .grant     (grant),
    .busy      (busy),
    .remaining (remaining),
    .done      (done),
    .tick      (tick)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n cycles; outputs are sampled and inputs driven 1 time unit
  // after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_remaining"}, 32'(remaining), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_tick"}, 32'(tick), 32'd0);
  endtask

  initial begin
    int           gcyc;
    int           ndone;
    logic [N-1:0] prev;
    logic [N-1:0] exp_g;

    reset = 1'b1;
    req   = '0;
    dur   = '0;
`ifdef TIMER_PAUSE_EN
    pause = 1'b0;
`endif
    step(2);
    check_idle_outputs("reset");
    reset = 1'b0;

    // Prescaler free-runs in IDLE: tick after 3 more edges, then clears.
    step(3);
    check("idle_tick_hi", 32'(tick), 32'd1);
    step(1);
    check("idle_tick_lo", 32'(tick), 32'd0);

    // Single request, dur0=3; mid-run req/dur changes must be ignored.
    req = 3'b001;
    dur = {8'd0, 8'd0, 8'd3};
    step(1); // c1
    check("single_grant_c1", 32'(grant), 32'b001);
    check("single_busy_c1", 32'(busy), 32'd1);
    check("single_rem_c1", 32'(remaining), 32'd3);
    check("single_done_c1", 32'(done), 32'd0);
    step(3); // c4
    check("single_tick_c4", 32'(tick), 32'd1);
    check("single_rem_c4", 32'(remaining), 32'd3);
    step(1); // c5
    check("single_rem_c5", 32'(remaining), 32'd2);
    step(1); // c6
    req = 3'b111;
    dur = {8'd9, 8'd9, 8'd9};
    step(6); // c12
    check("single_rem_c12", 32'(remaining), 32'd1);
    check("single_grant_c12", 32'(grant), 32'b001);
    check("single_done_c12", 32'(done), 32'd0);
    step(1); // c13
    check("single_done_c13", 32'(done), 32'b001);
    check("single_grant_c13", 32'(grant), 32'b001);
    check("single_rem_c13", 32'(remaining), 32'd0);
    req = 3'b000;
    step(1); // c14
    check("single_grant_c14", 32'(grant), 32'd0);
    check("single_done_c14", 32'(done), 32'd0);
    check("single_busy_c14", 32'(busy), 32'd0);

    // Zero duration on requester 1: grant and done together.
    req = 3'b010;
    dur = '0;
    step(1);
    check("zero_grant", 32'(grant), 32'b010);
    check("zero_done", 32'(done), 32'b010);
    check("zero_rem", 32'(remaining), 32'd0);
    req = 3'b000;
    step(1);
    check("zero_grant_drop", 32'(grant), 32'd0);
    check("zero_done_drop", 32'(done), 32'd0);

    // Abort: dur0=5, req0 dropped in c6.
    req = 3'b001;
    dur = {8'd0, 8'd0, 8'd5};
    step(1); // c1
    check("abort_grant_c1", 32'(grant), 32'b001);
    check("abort_rem_c1", 32'(remaining), 32'd5);
    step(5); // c6
    check("abort_rem_c6", 32'(remaining), 32'd4);
    req = 3'b000;
    step(1); // c7
    check("abort_grant_c7", 32'(grant), 32'd0);
    check("abort_done_c7", 32'(done), 32'd0);
    check("abort_rem_c7", 32'(remaining), 32'd0);
    // Pointer moved past requester 0: requester 1 wins with req=011.
    req = 3'b011;
    step(1); // c8
    check("abort_next_grant", 32'(grant), 32'b010);
    check("abort_next_done", 32'(done), 32'b010);
    step(1); // c9
    check("abort_gap_grant", 32'(grant), 32'd0);
    step(1); // c10: requester 0 re-arbitrated behind the pointer
    check("rearb_grant", 32'(grant), 32'b001);
    check("rearb_rem", 32'(remaining), 32'd5);

    // Reset mid-RUN at remaining=2 (ticks at c13, c17, c21).
    step(12); // c22
    check("rst_mid_rem", 32'(remaining), 32'd2);
    reset = 1'b1;
    req   = 3'b000;
    step(1);
    check_idle_outputs("rst_mid");
    reset = 1'b0;

    // Round-robin with all requesters held and dur=1; pointer restarts at 0.
    req = 3'b111;
    dur = {8'd1, 8'd1, 8'd1};
    exp_q = {3'b001, 3'b010, 3'b100, 3'b001};
    prev  = '0;
    gcyc  = 0;
    ndone = 0;
    for (int c = 1; c <= 23; c++) begin
      step(1);
      if (grant != '0 && prev == '0) begin
        if (exp_q.size() == 0) begin
          check("rr_extra_grant", 32'(grant), 32'd0);
        end else begin
          exp_g = exp_q.pop_front();
          check("rr_grant_order", 32'(grant), 32'(exp_g));
        end
        gcyc = c;
      end
      if (done != '0) begin
        ndone++;
        check("rr_done_owner", 32'(done), 32'(grant));
        check("rr_done_latency", 32'(c - gcyc), 32'd4);
      end
      prev = grant;
    end
    check("rr_grants_left", 32'(exp_q.size()), 32'd0);
    check("rr_done_count", 32'(ndone), 32'd4);
    req = 3'b000;
    step(1);
    check("rr_release", 32'(grant), 32'd0);

    // Abort on the final tick: no done.
    req = 3'b010;
    dur = {8'd0, 8'd1, 8'd0};
    step(1); // c1
    check("final_abort_grant", 32'(grant), 32'b010);
    step(3); // c4
    check("final_abort_tick", 32'(tick), 32'd1);
    check("final_abort_rem", 32'(remaining), 32'd1);
    req = 3'b000;
    step(1); // c5
    check("final_abort_grant_c5", 32'(grant), 32'd0);
    check("final_abort_done_c5", 32'(done), 32'd0);
    check("final_abort_rem_c5", 32'(remaining), 32'd0);
    step(1);
    check("final_abort_done_c6", 32'(done), 32'd0);

`ifdef TIMER_PAUSE_EN
    // Pause for 6 cycles during a dur=2 run: done moves from c9 to c15.
    req = 3'b100;
    dur = {8'd2, 8'd0, 8'd0};
    step(1); // c1
    check("pause_grant", 32'(grant), 32'b100);
    step(1); // c2
    pause = 1'b1;
    step(6); // c8
    pause = 1'b0;
    check("pause_rem_c8", 32'(remaining), 32'd2);
    step(1); // c9
    check("pause_done_c9", 32'(done), 32'd0);
    step(5); // c14
    check("pause_done_c14", 32'(done), 32'd0);
    step(1); // c15
    check("pause_done_c15", 32'(done), 32'b100);
    req = 3'b000;
    step(1);
    check("pause_release", 32'(grant), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
